// File: rtl/tcm_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tcm_mem_loader
// Description : Byte-stream to TCM bridge. Decodes load/dump command frames
//               from an inbound byte stream, writes whole words into one TCM
//               port or reads words back and streams them out LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module tcm_mem_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              tx_valid_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_wr_o,
    output logic [3:0]        mem_wr_o,
    input  logic [31:0]       mem_data_rd_i,
    output logic              busy_o
);

    localparam logic [7:0] c_CMD_WRITE = 8'h10;
    localparam logic [7:0] c_CMD_READ  = 8'h11;
    localparam logic [7:0] c_ACK_BYTE  = 8'hA5;
    localparam logic [7:0] c_ERR_BYTE  = 8'hEE;

    // WACK carries the single response byte: 0xA5 after a write, 0xEE for a bad command
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRITE = 3'd3,
        ST_WACK  = 3'd4,
        ST_RREQ  = 3'd5,
        ST_RWAIT = 3'd6,
        ST_RDATA = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic                is_wr_q, is_wr_d;
    logic [2:0]          hdr_cnt_q, hdr_cnt_d;
    logic [39:0]         hdr_q, hdr_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         word_q, word_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         len_q, len_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [3:0]          mem_wr_q, mem_wr_d;
    logic [31:0]         mem_data_wr_q, mem_data_wr_d;

    logic                w_rx_fire;
    logic                w_tx_fire;
    logic [47:0]         w_hdr_full;
    logic [15:0]         w_hdr_len;
    logic                w_unused_hdr;

    // Inbound bytes are only taken in the header/payload collecting states
    assign rx_ready_o = !rst_i && ((state_q == ST_IDLE) || (state_q == ST_HDR) ||
                                   (state_q == ST_WDATA));
    assign w_rx_fire  = rx_valid_i && rx_ready_o;
    assign w_tx_fire  = tx_valid_q && tx_ready_i;

    // Header as it stands once the final LEN byte arrives (byte 0 in bits 7:0)
    assign w_hdr_full = {rx_data_i, hdr_q};
    assign w_hdr_len  = w_hdr_full[47:32];
    // Byte-offset and upper address bits carry no meaning for a word-addressed TCM
    assign w_unused_hdr = ^{w_hdr_full[1:0], w_hdr_full[31:ADDR_W+2]};

    // Next-state and datapath decode for the frame sequencer
    always_comb begin
        state_d       = state_q;
        is_wr_d       = is_wr_q;
        hdr_cnt_d     = hdr_cnt_q;
        hdr_d         = hdr_q;
        byte_cnt_d    = byte_cnt_q;
        word_d        = word_q;
        addr_d        = addr_q;
        len_d         = len_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        mem_wr_d      = 4'h0;
        mem_data_wr_d = mem_data_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    if ((rx_data_i == c_CMD_WRITE) || (rx_data_i == c_CMD_READ)) begin
                        is_wr_d   = (rx_data_i == c_CMD_WRITE);
                        hdr_cnt_d = 3'd0;
                        state_d   = ST_HDR;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = c_ERR_BYTE;
                        state_d    = ST_WACK;
                    end
                end
            end
            ST_HDR: begin
                if (w_rx_fire) begin
                    hdr_d     = {rx_data_i, hdr_q[39:8]};
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    if (hdr_cnt_q == 3'd5) begin
                        addr_d     = w_hdr_full[ADDR_W+1:2];
                        len_d      = w_hdr_len;
                        byte_cnt_d = 2'd0;
                        if (is_wr_q) begin
                            if (w_hdr_len == 16'd0) begin
                                tx_valid_d = 1'b1;
                                tx_data_d  = c_ACK_BYTE;
                                state_d    = ST_WACK;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end else begin
                            state_d = (w_hdr_len == 16'd0) ? ST_IDLE : ST_RREQ;
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (w_rx_fire) begin
                    word_d     = {rx_data_i, word_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_wr_d      = 4'hF;
                        mem_data_wr_d = {rx_data_i, word_q[31:8]};
                        state_d       = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                addr_d     = addr_q + ADDR_W'(1);
                len_d      = len_q - 16'd1;
                byte_cnt_d = 2'd0;
                if (len_q == 16'd1) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = c_ACK_BYTE;
                    state_d    = ST_WACK;
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_WACK: begin
                if (w_tx_fire) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_RREQ: begin
                state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                word_d     = mem_data_rd_i;
                tx_valid_d = 1'b1;
                tx_data_d  = mem_data_rd_i[7:0];
                byte_cnt_d = 2'd0;
                state_d    = ST_RDATA;
            end
            ST_RDATA: begin
                if (w_tx_fire) begin
                    if (byte_cnt_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        addr_d     = addr_q + ADDR_W'(1);
                        len_d      = len_q - 16'd1;
                        state_d    = (len_q == 16'd1) ? ST_IDLE : ST_RREQ;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        word_d     = {8'h00, word_q[31:8]};
                        tx_data_d  = word_q[15:8];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any partial frame at once
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            is_wr_q       <= 1'b0;
            hdr_cnt_q     <= 3'd0;
            hdr_q         <= 40'd0;
            byte_cnt_q    <= 2'd0;
            word_q        <= 32'd0;
            addr_q        <= '0;
            len_q         <= 16'd0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'd0;
            mem_wr_q      <= 4'h0;
            mem_data_wr_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            is_wr_q       <= is_wr_d;
            hdr_cnt_q     <= hdr_cnt_d;
            hdr_q         <= hdr_d;
            byte_cnt_q    <= byte_cnt_d;
            word_q        <= word_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            mem_wr_q      <= mem_wr_d;
            mem_data_wr_q <= mem_data_wr_d;
        end
    end

    assign tx_valid_o    = tx_valid_q;
    assign tx_data_o     = tx_data_q;
    assign mem_addr_o    = addr_q;
    assign mem_data_wr_o = mem_data_wr_q;
    assign mem_wr_o      = mem_wr_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tcm_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcm_mem_loader
// Description : Directed self-checking bench for tcm_mem_loader with a
//               read-first TCM model and a write-strobe monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcm_mem_loader;

    localparam int ADDR_W = 14;

    logic              clk_i;
    logic              rst_i;
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              rx_ready_o;
    logic              tx_valid_o;
    logic [7:0]        tx_data_o;
    logic              tx_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_wr_o;
    logic [3:0]        mem_wr_o;
    logic [31:0]       mem_data_rd_i;
    logic              busy_o;

    int total = 0;
    int bad   = 0;
    int strobes = 0;
    int odd_strobes = 0;
    int s0;
    logic [7:0]        rxq[$];
    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    tcm_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_ready_o   (rx_ready_o),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .tx_ready_i   (tx_ready_i),
        .mem_addr_o   (mem_addr_o),
        .mem_data_wr_o(mem_data_wr_o),
        .mem_wr_o     (mem_wr_o),
        .mem_data_rd_i(mem_data_rd_i),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Read-first TCM model plus a log of every strobed cycle
    always @(posedge clk_i) begin
        if (mem_wr_o == 4'hF) mem[mem_addr_o] <= mem_data_wr_o;
        mem_data_rd_i <= mem[mem_addr_o];
        if (mem_wr_o != 4'h0) begin
            strobes++;
            if (mem_wr_o != 4'hF) odd_strobes++;
            wa.push_back(mem_addr_o);
            wd.push_back(mem_data_wr_o);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        while (!rx_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!rx_ready_o) check("rx_ready_timeout", {31'd0, rx_ready_o}, 32'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] a, input logic [15:0] n);
        send_byte(cmd);
        send_word(a);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    // Collect n tx bytes; with stall set, ready is high one cycle in three
    task automatic recv(input int n, input bit stall);
        int cyc = 0;
        bit pend = 1'b0;
        logic [7:0] held = 8'h00;
        rxq.delete();
        while (rxq.size() < n && cyc < 400) begin
            tx_ready_i = stall ? ((cyc % 3) == 2) : 1'b1;
            if (pend && tx_valid_o) check("tx_stable", {24'd0, tx_data_o}, {24'd0, held});
            if (tx_valid_o && tx_ready_i) begin
                rxq.push_back(tx_data_o);
                pend = 1'b0;
            end else if (tx_valid_o) begin
                pend = 1'b1;
                held = tx_data_o;
            end
            @(negedge clk_i);
            cyc++;
        end
        tx_ready_i = 1'b0;
        check("recv_count", rxq.size(), n);
    endtask

    task automatic expect_bytes(input string tag, input logic [63:0] exp, input int n);
        for (int i = 0; i < n; i++)
            check(tag, {24'd0, (i < rxq.size()) ? rxq[i] : 8'hXX}, {24'd0, exp[8*i +: 8]});
    endtask

    initial begin
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tx_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset state
        check("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
        check("rst_mem_wr", {28'd0, mem_wr_o}, 32'd0);
        check("rst_mem_addr", {18'd0, mem_addr_o}, 32'd0);
        check("rst_mem_data", mem_data_wr_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        check("idle_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        @(negedge clk_i);

        // 1: two-word write at byte address 0x100 -> words 0x40, 0x41
        s0 = strobes;
        send_hdr(8'h10, 32'h0000_0100, 16'd2);
        send_word(32'h4433_2211);
        send_word(32'h8877_6655);
        recv(1, 1'b0);
        expect_bytes("t1_ack", 64'hA5, 1);
        check("t1_strobes", strobes - s0, 32'd2);
        check("t1_addr0", {18'd0, wa[wa.size()-2]}, 32'h40);
        check("t1_addr1", {18'd0, wa[wa.size()-1]}, 32'h41);
        check("t1_mem40", mem[14'h40], 32'h4433_2211);
        check("t1_mem41", mem[14'h41], 32'h8877_6655);
        check("t1_busy", {31'd0, busy_o}, 32'd0);

        // 2: read the same two words back
        send_hdr(8'h11, 32'h0000_0100, 16'd2);
        recv(8, 1'b0);
        expect_bytes("t2_rd", 64'h8877_6655_4433_2211, 8);
        repeat (3) @(negedge clk_i);
        check("t2_no_extra", {31'd0, tx_valid_o}, 32'd0);

        // 3: write across the top of the address space, then read back
        s0 = strobes;
        send_hdr(8'h10, 32'h0000_FFFC, 16'd2);
        send_word(32'hEFBE_ADDE);
        send_word(32'h0403_0201);
        recv(1, 1'b0);
        expect_bytes("t3_ack", 64'hA5, 1);
        check("t3_strobes", strobes - s0, 32'd2);
        check("t3_addr0", {18'd0, wa[wa.size()-2]}, 32'h3FFF);
        check("t3_addr1", {18'd0, wa[wa.size()-1]}, 32'h0000);
        check("t3_data0", wd[wd.size()-2], 32'hEFBE_ADDE);
        check("t3_data1", wd[wd.size()-1], 32'h0403_0201);
        send_hdr(8'h11, 32'h1234_FFFC, 16'd2);
        recv(8, 1'b0);
        expect_bytes("t3_rd", 64'h0403_0201_EFBE_ADDE, 8);

        // 4: read with a stalling sink
        send_hdr(8'h11, 32'h0000_0100, 16'd2);
        recv(8, 1'b1);
        expect_bytes("t4_rd", 64'h8877_6655_4433_2211, 8);

        // 5: unknown command, then zero-length frames
        s0 = strobes;
        send_byte(8'h7F);
        recv(1, 1'b0);
        expect_bytes("t5_err", 64'hEE, 1);
        repeat (4) @(negedge clk_i);
        check("t5_tx_idle", {31'd0, tx_valid_o}, 32'd0);
        check("t5_busy", {31'd0, busy_o}, 32'd0);
        send_hdr(8'h10, 32'h0000_0200, 16'd0);
        recv(1, 1'b0);
        expect_bytes("t5_len0_ack", 64'hA5, 1);
        send_hdr(8'h11, 32'h0000_0200, 16'd0);
        repeat (5) @(negedge clk_i);
        check("t5_len0_rd_tx", {31'd0, tx_valid_o}, 32'd0);
        check("t5_len0_rd_busy", {31'd0, busy_o}, 32'd0);
        check("t5_strobes", strobes - s0, 32'd0);

        // 6: reset in the middle of a payload word
        s0 = strobes;
        send_hdr(8'h10, 32'h0000_0200, 16'd1);
        send_byte(8'hCA);
        send_byte(8'hFE);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("t6_strobes", strobes - s0, 32'd0);
        check("t6_tx_idle", {31'd0, tx_valid_o}, 32'd0);
        send_hdr(8'h10, 32'h0000_0200, 16'd1);
        send_word(32'hBEBA_FECA);
        recv(1, 1'b0);
        expect_bytes("t6_ack", 64'hA5, 1);
        check("t6_strobes_after", strobes - s0, 32'd1);
        check("t6_addr", {18'd0, wa[wa.size()-1]}, 32'h80);
        check("t6_data", wd[wd.size()-1], 32'hBEBA_FECA);
        send_hdr(8'h11, 32'h0000_0200, 16'd1);
        recv(4, 1'b0);
        expect_bytes("t6_rd", 64'hBEBA_FECA, 4);

        check("strobe_shape", odd_strobes, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
